// File: rtl/arch_state_dumper_pkg.sv
// Core-wide widths, dump FSM encodings and the beat record shared by the
// architectural state dumper, its interface and the bench.
`default_nettype none

package arch_state_dumper_pkg;

  localparam int ARCH_REGS = 32;
  localparam int AREG_W    = $clog2(ARCH_REGS);
  localparam int PREG_W    = 7;
  localparam int DATA_W    = 32;

  typedef logic [1:0] dump_state_e;
  localparam dump_state_e IDLE    = 2'd0;
  localparam dump_state_e LOOKUP  = 2'd1;
  localparam dump_state_e CAPTURE = 2'd2;
  localparam dump_state_e SEND    = 2'd3;

  typedef struct packed {
    logic [AREG_W-1:0] areg;
    logic [PREG_W-1:0] preg;
    logic [DATA_W-1:0] data;
    logic              last;
    logic              stale;
  } dump_beat_t;

  // A reversed range collapses to a single beat of the first register.
  function automatic logic [AREG_W-1:0] dump_end(input logic [AREG_W-1:0] first,
                                                 input logic [AREG_W-1:0] last);
    return (first > last) ? first : last;
  endfunction

endpackage

`default_nettype wire

// File: rtl/arch_state_dumper_if.sv
// Request, rename-map/PRF read and output-beat signals of the state dumper.
// slave = the dumper itself, master = the core/consumer side.
`default_nettype none

interface arch_state_dumper_if;
  import arch_state_dumper_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [AREG_W-1:0] req_first;
  logic [AREG_W-1:0] req_last;
  logic [AREG_W-1:0] map_raddr;
  logic [PREG_W-1:0] map_rdata;
  logic              prf_ren;
  logic [PREG_W-1:0] prf_raddr;
  logic [DATA_W-1:0] prf_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [AREG_W-1:0] out_areg;
  logic [PREG_W-1:0] out_preg;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_stale;

  modport slave (
    input  req_valid, req_first, req_last, map_rdata, prf_rdata, out_ready,
    output req_ready, map_raddr, prf_ren, prf_raddr,
    output out_valid, out_areg, out_preg, out_data, out_last, out_stale
  );

  modport master (
    output req_valid, req_first, req_last, map_rdata, prf_rdata, out_ready,
    input  req_ready, map_raddr, prf_ren, prf_raddr,
    input  out_valid, out_areg, out_preg, out_data, out_last, out_stale
  );

endinterface

`default_nettype wire

// File: rtl/arch_state_dumper.sv
// Walks a range of architectural registers, resolves each through the committed
// rename map and the PRF, and streams one {areg, preg, data} beat per register.
`default_nettype none

module arch_state_dumper
  import arch_state_dumper_pkg::*;
(
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic          pipe_idle,
  input  wire logic          dump_abort,
  output      logic          busy,
  arch_state_dumper_if.slave bus
);

  localparam logic [AREG_W-1:0] AREG_ONE = AREG_W'(1);

  dump_state_e       state_q, state_d;
  logic [AREG_W-1:0] cur_q,   cur_d;
  logic [AREG_W-1:0] last_q,  last_d;
  logic [PREG_W-1:0] preg_q,  preg_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              stale_q, stale_d;

  logic       accept;
  logic       cur_is_x0;
  logic       final_beat;
  dump_beat_t beat;

  assign busy       = (state_q != IDLE);
  assign accept     = bus.req_valid & bus.req_ready;
  assign cur_is_x0  = (cur_q == '0);
  assign final_beat = (cur_q == last_q);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    preg_d  = preg_q;
    data_d  = data_q;
    stale_d = stale_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          cur_d   = bus.req_first;
          last_d  = dump_end(bus.req_first, bus.req_last);
          stale_d = 1'b0;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        preg_d  = cur_is_x0 ? '0 : bus.map_rdata;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        data_d  = cur_is_x0 ? '0 : bus.prf_rdata;
        state_d = SEND;
      end
      SEND: begin
        if (bus.out_ready) begin
          if (final_beat) begin
            state_d = IDLE;
          end else begin
            cur_d   = cur_q + AREG_ONE;
            state_d = LOOKUP;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A non-idle pipe anywhere in the dump means the snapshot may be torn.
    if (busy && !pipe_idle) stale_d = 1'b1;
    // Abort overrides a same-cycle handshake: that beat is not delivered.
    if (busy && dump_abort) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      last_q  <= '0;
      preg_q  <= '0;
      data_q  <= '0;
      stale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      preg_q  <= preg_d;
      data_q  <= data_d;
      stale_q <= stale_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE) & pipe_idle;

  // Map and PRF read ports are shared with the core; drive them only in LOOKUP.
  assign bus.map_raddr = (state_q == LOOKUP) ? cur_q : '0;
  assign bus.prf_raddr = (state_q == LOOKUP) ? bus.map_rdata : '0;
  assign bus.prf_ren   = (state_q == LOOKUP) & ~cur_is_x0;

  always_comb begin
    beat       = '0;
    beat.areg  = cur_q;
    beat.preg  = preg_q;
    beat.data  = data_q;
    beat.last  = final_beat;
    beat.stale = stale_q & final_beat;
    if (state_q != SEND) beat = '0;
  end

  assign bus.out_valid = (state_q == SEND);
  assign bus.out_areg  = beat.areg;
  assign bus.out_preg  = beat.preg;
  assign bus.out_data  = beat.data;
  assign bus.out_last  = beat.last;
  assign bus.out_stale = beat.stale;

endmodule

`default_nettype wire
